// File: rtl/lcd_glyph_line_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_glyph_line_scheduler
//   Draws one horizontal band of NUM_TILES 64x64 glyph tiles on the LCD.
//   A double-buffered character string is written by the measurement formatter
//   and committed on frame_start. On each line_start inside the band, one glyph
//   row per tile is prefetched from the shared ROM into a line buffer. During
//   active video the line buffer is serialised MSB-first into RGB.
//
//   Optional feature macro: LCD_GLYPH_BLINK_EN (adds per-tile blink bit and
//   char_blink input, blinking with a 32-frame half period).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   ready_sig, column_addr_sig,
//   row_addr_sig                  pixel timing from the timing generator
//   line_start, fetch_row         hblank pulse and the row to prefetch
//   frame_start                   vblank pulse, commits shadow string
//   char_we, char_idx, char_code  shadow string write port
//   rom_en, rom_addr, rom_data    glyph ROM read port ({code, row[5:0]})
//   red_sig, green_sig, blue_sig  registered pixel colour
//   busy                          prefetch in progress
//   overrun                       sticky: line_start arrived while busy
// -----------------------------------------------------------------------------
module lcd_glyph_line_scheduler #(
    parameter int          NUM_TILES = 8,
    parameter int          CODE_W    = 4,
    parameter int          ROM_LAT   = 1,
    parameter logic [10:0] X0        = 11'd64,
    parameter logic [10:0] Y0        = 11'd32,
    parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR  = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready_sig,
    input  logic [10:0]       column_addr_sig,
    input  logic [10:0]       row_addr_sig,
    input  logic              line_start,
    input  logic [10:0]       fetch_row,
    input  logic              frame_start,
    input  logic              char_we,
    input  logic [3:0]        char_idx,
    input  logic [CODE_W-1:0] char_code,
`ifdef LCD_GLYPH_BLINK_EN
    input  logic              char_blink,
`endif
    output logic              rom_en,
    output logic [CODE_W+5:0] rom_addr,
    input  logic [63:0]       rom_data,
    output logic [7:0]        red_sig,
    output logic [7:0]        green_sig,
    output logic [7:0]        blue_sig,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state_q;
    logic [3:0]        tile_q;
    logic [1:0]        drain_q;
    logic [5:0]        grow_q;
    logic              rom_en_q;
    logic [CODE_W+5:0] rom_addr_q;
    logic              line_valid_q;
    logic              overrun_q;

    logic [CODE_W-1:0] shadow_q [NUM_TILES];
    logic [CODE_W-1:0] active_q [NUM_TILES];
    logic [CODE_W-1:0] active_d [NUM_TILES];
    logic [63:0]       linebuf_q [NUM_TILES];

    // Tile-index delay pipe: stage k holds the issue from k cycles ago.
    logic [ROM_LAT:1]      vld_pipe_q;
    logic [ROM_LAT:1][3:0] tile_pipe_q;

    logic [23:0]       rgb_q;

`ifdef LCD_GLYPH_BLINK_EN
    logic [NUM_TILES-1:0] sh_blink_q, act_blink_q;
    logic [5:0]           frm_cnt_q;   // bit 5 is the blink phase
    logic                 pblink;
`endif

    // ---------------- string double buffer ----------------
    // Fetch addresses use the post-commit view so that a frame_start during
    // FETCH affects every tile not yet issued.
    always_comb begin
        for (int i = 0; i < NUM_TILES; i++)
            active_d[i] = frame_start ? shadow_q[i] : active_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TILES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
`ifdef LCD_GLYPH_BLINK_EN
            sh_blink_q  <= '0;
            act_blink_q <= '0;
            frm_cnt_q   <= '0;
`endif
        end else begin
            // Same-cycle write lands in shadow only; active copies the old shadow.
            for (int i = 0; i < NUM_TILES; i++) begin
                if (char_we && char_idx == 4'(i)) begin
                    shadow_q[i] <= char_code;
`ifdef LCD_GLYPH_BLINK_EN
                    sh_blink_q[i] <= char_blink;
`endif
                end
                if (frame_start) active_q[i] <= shadow_q[i];
            end
`ifdef LCD_GLYPH_BLINK_EN
            if (frame_start) begin
                act_blink_q <= sh_blink_q;
                frm_cnt_q   <= frm_cnt_q + 6'd1;
            end
`endif
        end
    end

    // ---------------- prefetch FSM ----------------
    logic [11:0]       frow12;
    logic              fetch_in_band;
    logic [3:0]        nxt_t;
    logic [CODE_W-1:0] nxt_code;
    logic [5:0]        grow_d;

    always_comb begin
        frow12        = {1'b0, fetch_row};
        fetch_in_band = (frow12 >= {1'b0, Y0}) && (frow12 < {1'b0, Y0} + 12'd64);
        grow_d        = (state_q == IDLE) ? (fetch_row[5:0] - Y0[5:0]) : grow_q;
        nxt_t         = (state_q == IDLE) ? 4'd0 : tile_q + 4'd1;
        nxt_code      = '0;
        for (int i = 0; i < NUM_TILES; i++)
            if (nxt_t == 4'(i)) nxt_code = active_d[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tile_q       <= '0;
            drain_q      <= '0;
            grow_q       <= '0;
            rom_en_q     <= 1'b0;
            rom_addr_q   <= '0;
            line_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rom_en_q <= 1'b0;
            if (line_start && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (line_start) begin
                        if (fetch_in_band) begin
                            grow_q     <= grow_d;
                            tile_q     <= '0;
                            rom_en_q   <= 1'b1;
                            rom_addr_q <= {nxt_code, grow_d};
                            state_q    <= FETCH;
                        end else begin
                            line_valid_q <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (tile_q == 4'(NUM_TILES - 1)) begin
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end else begin
                        tile_q     <= nxt_t;
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= {nxt_code, grow_q};
                    end
                end
                DRAIN: begin
                    // Last capture lands on the same edge that leaves DRAIN.
                    if (drain_q == 2'(ROM_LAT - 1)) begin
                        line_valid_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---------------- ROM capture ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q  <= '0;
            tile_pipe_q <= '0;
            for (int i = 0; i < NUM_TILES; i++) linebuf_q[i] <= '0;
        end else begin
            vld_pipe_q[1]  <= rom_en_q;
            tile_pipe_q[1] <= tile_q;
            for (int k = 2; k <= ROM_LAT; k++) begin
                vld_pipe_q[k]  <= vld_pipe_q[k-1];
                tile_pipe_q[k] <= tile_pipe_q[k-1];
            end
            if (vld_pipe_q[ROM_LAT])
                for (int i = 0; i < NUM_TILES; i++)
                    if (tile_pipe_q[ROM_LAT] == 4'(i)) linebuf_q[i] <= rom_data;
        end
    end

    // ---------------- pixel path ----------------
    // Band compares run at 12 bits so the band end never wraps past column 2047.
    logic [11:0] col12, row12;
    logic [10:0] dx;
    logic [63:0] prow;
    logic [5:0]  bitsel;
    logic        row_in, col_in, lit;

    always_comb begin
        col12  = {1'b0, column_addr_sig};
        row12  = {1'b0, row_addr_sig};
        row_in = (row12 >= {1'b0, Y0}) && (row12 < {1'b0, Y0} + 12'd64);
        col_in = (col12 >= {1'b0, X0}) && (col12 < {1'b0, X0} + 12'(64 * NUM_TILES));
        dx     = column_addr_sig - X0;
        bitsel = 6'd63 - dx[5:0];
        prow   = '0;
`ifdef LCD_GLYPH_BLINK_EN
        pblink = 1'b0;
`endif
        for (int i = 0; i < NUM_TILES; i++)
            if (dx[10:6] == 5'(i)) begin
                prow = linebuf_q[i];
`ifdef LCD_GLYPH_BLINK_EN
                pblink = act_blink_q[i];
`endif
            end
        lit = ready_sig && line_valid_q && row_in && col_in && prow[bitsel];
`ifdef LCD_GLYPH_BLINK_EN
        if (frm_cnt_q[5] && pblink) lit = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) rgb_q <= BG_COLOR;
        else     rgb_q <= lit ? FG_COLOR : BG_COLOR;
    end

    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = overrun_q;
    assign red_sig   = rgb_q[23:16];
    assign green_sig = rgb_q[15:8];
    assign blue_sig  = rgb_q[7:0];

endmodule

// File: tb/tb_lcd_glyph_line_scheduler.sv
module tb_lcd_glyph_line_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_sig;
  logic [10:0] column_addr_sig, row_addr_sig, fetch_row;
  logic        line_start, frame_start, char_we;
  logic [3:0]  char_idx, char_code;
`ifdef LCD_GLYPH_BLINK_EN
  logic        char_blink = 1'b0;
`endif
  logic        rom_en;
  logic [9:0]  rom_addr;
  logic [63:0] rom_data = '0;
  logic [7:0]  red_sig, green_sig, blue_sig;
  logic        busy, overrun;

  lcd_glyph_line_scheduler dut (
    .clk(clk), .rst(rst), .ready_sig(ready_sig),
    .column_addr_sig(column_addr_sig), .row_addr_sig(row_addr_sig),
    .line_start(line_start), .fetch_row(fetch_row), .frame_start(frame_start),
    .char_we(char_we), .char_idx(char_idx), .char_code(char_code),
`ifdef LCD_GLYPH_BLINK_EN
    .char_blink(char_blink),
`endif
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .red_sig(red_sig), .green_sig(green_sig), .blue_sig(blue_sig),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // glyph ROM: code 1 has a distinctive first/last-pixel pattern
  function automatic logic [63:0] rom_fn(input logic [9:0] a);
    if (a[9:6] == 4'd1) return 64'h8000_0000_0000_0001;
    return {a, 44'h0, a};
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_fn(rom_addr);

  // scoreboard state
  logic [9:0]  exp_addr[$];
  logic [23:0] exp_px[$];
  logic [3:0]  msh [8];
  logic [3:0]  mact[8];
  logic [63:0] mlb [8];
  logic        mvalid = 1'b0;
  bit          mon_en = 1'b1;

  always @(negedge clk) begin
    if (mon_en && !rst && rom_en) begin
      if (exp_addr.size() == 0) chk("rom_en_unexp", {63'b0, rom_en}, 64'd0);
      else chk("rom_addr", {54'b0, rom_addr}, {54'b0, exp_addr.pop_front()});
    end
  end

  task automatic tick; @(negedge clk); endtask

  task automatic wr(input int idx, input logic [3:0] code);
    char_we = 1'b1; char_idx = 4'(idx); char_code = code;
    tick;
    char_we = 1'b0;
    if (idx < 8) msh[idx] = code;
  endtask

  task automatic frame;
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    for (int i = 0; i < 8; i++) mact[i] = msh[i];
  endtask

  function automatic logic [23:0] px_model(input int col, input int row, input bit rdy);
    int dx;
    if (!rdy || !mvalid) return 24'h0;
    if (row < 32 || row >= 96 || col < 64 || col >= 64 + 512) return 24'h0;
    dx = col - 64;
    return mlb[dx / 64][63 - (dx % 64)] ? 24'hFFFFFF : 24'h0;
  endfunction

  task automatic px(input int col, input int row, input bit rdy);
    column_addr_sig = 11'(col); row_addr_sig = 11'(row); ready_sig = rdy;
    exp_px.push_back(px_model(col, row, rdy));
    tick;
    chk($sformatf("px c%0d r%0d", col, row), {40'b0, red_sig, green_sig, blue_sig},
        {40'b0, exp_px.pop_front()});
  endtask

  // line_start for row; optional second line_start after inj busy cycles
  task automatic do_fetch(input int row, input int inj);
    int n;
    bit inb;
    logic [5:0] g;
    inb = (row >= 32 && row < 96);
    g = 6'(row - 32);
    if (inb) for (int i = 0; i < 8; i++) exp_addr.push_back({mact[i], g});
    fetch_row = 11'(row); line_start = 1'b1;
    tick;
    line_start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == inj) line_start = 1'b1;
      tick;
      line_start = 1'b0;
    end
    chk($sformatf("busy_cycles r%0d", row), 64'(n), inb ? 64'd9 : 64'd0);
    chk("addr_q_drained", 64'(exp_addr.size()), 64'd0);
    exp_addr.delete();
    if (inb) begin
      for (int i = 0; i < 8; i++) mlb[i] = rom_fn({mact[i], g});
      mvalid = 1'b1;
    end else mvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready_sig = 1'b1; column_addr_sig = 11'd64; row_addr_sig = 11'd35;
    fetch_row = '0; line_start = 0; frame_start = 0; char_we = 0; char_idx = 0; char_code = 0;
    for (int i = 0; i < 8; i++) begin msh[i] = 0; mact[i] = 0; mlb[i] = 0; end
    tick; tick;
    chk("rst_rom_en", {63'b0, rom_en}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_overrun", {63'b0, overrun}, 64'd0);
    chk("rst_rgb", {40'b0, red_sig, green_sig, blue_sig}, 64'd0);
    rst = 1'b0;
    px(64, 35, 1);
    px(64, 35, 0);

    // fetch sequence
    for (int i = 0; i < 8; i++) wr(i, 4'(i + 1));
    frame;
    do_fetch(35, 0);

    // pixel map
    px(64, 35, 1); px(65, 35, 1); px(127, 35, 1); px(63, 35, 1); px(576, 35, 1);
    px(575, 35, 1); px(191, 35, 1); px(64, 35, 0); px(2047, 35, 1); px(64, 31, 1);
    px(64, 95, 1); px(64, 96, 1);
    for (int k = 0; k < 20; k++)
      px(int'($urandom_range(700, 0)), int'($urandom_range(100, 28)), bit'($urandom_range(1, 0) != 0));

    // out-of-band fetch
    do_fetch(96, 0);
    px(64, 96, 1); px(64, 35, 1);

    // overrun + uncommitted write
    wr(2, 4'd9);
    do_fetch(40, 3);
    chk("overrun_sticky", {63'b0, overrun}, 64'd1);
    px(64, 40, 1); px(200, 40, 1);
    frame;
    do_fetch(35, 0);
    px(190, 35, 1); px(191, 35, 1);

    // ignored write index
    wr(12, 4'd15);
    frame;
    do_fetch(32, 0);
    px(64, 32, 1);

    // reset mid-fetch
    mon_en = 0;
    fetch_row = 11'd50; line_start = 1'b1;
    tick;
    line_start = 1'b0;
    tick; tick;
    chk("midfetch_busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    tick;
    chk("rst_mid_busy", {63'b0, busy}, 64'd0);
    chk("rst_mid_rom_en", {63'b0, rom_en}, 64'd0);
    chk("rst_mid_overrun", {63'b0, overrun}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin msh[i] = 0; mact[i] = 0; mlb[i] = 0; end
    mvalid = 1'b0;
    mon_en = 1;
    tick;
    chk("post_rst_rom_en", {63'b0, rom_en}, 64'd0);
    px(64, 35, 1);
    // all-zero strings after reset: code 0 row 3 fetch
    do_fetch(35, 0);
    px(127, 35, 1); px(126, 35, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
